// File: rtl/sm4_tau_engine.sv
// Sequential SM4 tau: applies the SM4 S-box to every byte of a BYTES-wide word,
// LANES bytes per cycle, with valid/ready handshakes on input and output.
module sm4_tau_engine #(
    parameter int unsigned BYTES = 4,
    parameter int unsigned LANES = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [8*BYTES-1:0]   in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [8*BYTES-1:0]   out_data_o,
    output logic                 busy_o
);

    localparam int unsigned DW    = 8 * BYTES;
    localparam int unsigned STEPS = (LANES == 0) ? 1 : BYTES / LANES;
    localparam int unsigned SW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    if (BYTES < 1 || BYTES > 16 || LANES < 1 || (BYTES % LANES) != 0) begin : g_bad_params
        $error("sm4_tau_engine: BYTES must be 1..16 and LANES must divide BYTES");
    end

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [7:0] SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    logic [1:0]    state_q, state_d;
    logic [SW-1:0] step_q,  step_d;
    logic [DW-1:0] work_q,  work_d;

    logic [7:0] lane_in  [LANES];
    logic [7:0] lane_out [LANES];

    // Lane j reads byte step*LANES+j of the work register.
    always_comb begin : lane_mux
        for (int j = 0; j < int'(LANES); j++) begin
            lane_in[j] = work_q[8*j +: 8];
            for (int s = 1; s < int'(STEPS); s++) begin
                if (step_q == SW'(s)) begin
                    lane_in[j] = work_q[8*(s*int'(LANES)+j) +: 8];
                end
            end
        end
    end

    for (genvar j = 0; j < int'(LANES); j++) begin : g_lane
        assign lane_out[j] = SBOX[lane_in[j]];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin : state_reg
        if (!rst_ni) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            work_q  <= work_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        step_d  = step_q;
        work_d  = work_q;
        if (flush_i) begin
            // Abort wins over any handshake this cycle; the work register is left stale.
            state_d = S_IDLE;
            step_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid_i) begin
                        work_d  = in_data_i;
                        step_d  = '0;
                        state_d = S_BUSY;
                    end
                end
                S_BUSY: begin
                    for (int s = 0; s < int'(STEPS); s++) begin
                        if (step_q == SW'(s)) begin
                            for (int j = 0; j < int'(LANES); j++) begin
                                work_d[8*(s*int'(LANES)+j) +: 8] = lane_out[j];
                            end
                        end
                    end
                    if (step_q == SW'(STEPS - 1)) begin
                        step_d  = '0;
                        state_d = S_DONE;
                    end else begin
                        step_d = step_q + SW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready_i) begin
                        if (in_valid_i) begin
                            work_d  = in_data_i;
                            step_d  = '0;
                            state_d = S_BUSY;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    step_d  = '0;
                end
            endcase
        end
    end

    // Accepting in DONE lets a consumer-ready cycle also take the next word.
    assign in_ready_o  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready_i);
    assign out_valid_o = (state_q == S_DONE);
    assign out_data_o  = work_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule

// File: doc/sm4_tau_engine.md
# sm4_tau_engine

Sequential SM4 non-linear transform (tau) unit: applies the SM4 S-box to every byte of a BYTES-wide word. It time-multiplexes LANES S-box lookups per cycle, so area trades against latency. It sits between the round/key-expansion datapath and the linear transform L/L', with valid/ready handshakes on both sides. It supersedes direct per-byte S-box instantiation in the round logic.

## Interface
- BYTES, default 4: bytes per word; data width is 8*BYTES; legal values 1..16.
- LANES, default 4: S-box lookups per cycle; must divide BYTES, otherwise elaboration error.
- STEPS, derived as BYTES/LANES: substitution cycles per word. Not user-overridable.
- clk_i  in  1  clock; all state changes on its rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous abort; discards any word in flight.
- in_valid_i  in  1  input word valid.
- in_ready_o  out  1  engine can accept a word.
- in_data_i  in  8*BYTES  word to substitute; byte b is bits [8b+7:8b].
- out_valid_o  out  1  substituted word available.
- out_ready_i  in  1  consumer accepts the word.
- out_data_o  out  8*BYTES  substituted word.
- busy_o  out  1  high whenever state is not IDLE.

## Operation
- Contains LANES instances of the existing combinational 256-entry SM4 S-box lookup, plus a work register of 8*BYTES bits.
- Contains a step counter of width max(1, $clog2(STEPS)).
- FSM states: IDLE, BUSY, DONE.
- IDLE
  - in_ready_o=1.
  - On in_valid_i&&in_ready_o: load in_data_i into the work register, clear step to 0, go to BUSY.
- BUSY
  - Each cycle, lane j substitutes byte step*LANES+j of the work register in place. Byte 0 group first.
  - step increments each cycle.
  - When step==STEPS-1, that cycle's substitution completes; go to DONE and reset step to 0.
- DONE
  - out_valid_o=1 and out_data_o = work register.
  - The data is held stable until out_ready_i.
  - On out_ready_i, if in_valid_i is also high:
    - accept a new word in the same cycle: in_ready_o=out_ready_i in DONE;
    - load it and go to BUSY.
  - On out_ready_i without in_valid_i, go to IDLE.
- in_ready_o is 0 in BUSY; the engine does not accept a word mid-substitution.
- flush_i has priority over every transition:
  - next state IDLE, step=0, work register retained but invalid;
  - any handshake in the same cycle is ignored: no word is accepted and no word is counted as delivered.
- Bytes not yet substituted pass through unchanged in the work register. out_data_o is only meaningful while out_valid_o=1.

## Timing
- Reset (rst_ni low, asynchronous): state=IDLE, step=0, work register=0.
  - Outputs during reset: in_ready_o=1, out_valid_o=0, out_data_o=0, busy_o=0.
- Latency: the word accepted at edge E0 has out_valid_o=1 after edge E0+STEPS. That is STEPS cycles in BUSY, then DONE.
  - LANES=4, BYTES=4: 1 BUSY cycle.
  - LANES=1: 4 BUSY cycles.
- Throughput with out_ready_i held high: one word per STEPS+1 cycles.
- in_ready_o and out_valid_o are registered-state decodes, except in_ready_o in DONE. That term depends combinationally on out_ready_i; there is no other combinational input-to-output path.
- rst_ni asserted mid-BUSY or mid-DONE: immediate return to the reset values; the pending word is lost.
- out_valid_o, once high, never drops without out_ready_i, flush_i or reset.

## Test plan
- Reset values, default parameters:
  - stimulus: hold rst_ni=0 with random inputs;
  - required: in_ready_o=1, out_valid_o=0, busy_o=0, out_data_o=0.
  - Release reset: no spurious out_valid_o.
- Single word, LANES=4:
  - stimulus: in_data_i=0x03020100;
  - required: out_data_o=0xFEE990D6 with out_valid_o one cycle after acceptance.
- Serial mode, LANES=1:
  - stimulus: in_data_i=0xFF800000;
  - required: out_data_o=0x48EAD6D6 after exactly 4 BUSY cycles; busy_o high throughout.
- Backpressure:
  - stimulus: hold out_ready_i=0 for 10 cycles after out_valid_o;
  - required: out_data_o stable and in_ready_o=0.
  - Then stimulus: out_ready_i=1 with in_valid_i=1 carrying 0x00000001;
  - required: the new word is accepted in the same cycle; next result 0xD6D6D690.
- Flush and reset mid-operation, LANES=1:
  - stimulus: assert flush_i in the 2nd BUSY cycle;
  - required: IDLE next cycle, no out_valid_o for that word, and the next word is processed correctly.
  - Repeat with rst_ni pulsed low mid-DONE;
  - required: out_valid_o drops asynchronously.
- Exhaustive check, BYTES=4, LANES=2:
  - stimulus: stream all 256 byte values replicated across all 4 byte positions, with random out_ready_i stalls;
  - required: every output byte matches the SM4 S-box (0x00→0xD6, 0xFF→0x48, 0x80→0xEA), in order, with no drops or duplicates.
